cache_controller: RTL and testbench
===================================

// Module: cache_controller
// PURPOSE
//  Direct-mapped, read-only cache controller between the CPU request stage and main memory.
//  Accepts word read requests (cache_read + address) and returns read_data with a one-cycle cache_ready pulse.
//  On a miss it fetches a whole block from main memory, installs it, then responds.
//  Keeps hit/miss counters for hit-rate measurement over the CPU's sequential access run.
// PARAMETERS
//  ADDR_W      15  word address width (32K words of main memory)
//  DATA_W      32  word width
//  INDEX_W      8  line index width (256 lines)
//  OFFSET_W     2  word offset in block (4 words/block); TAG_W = ADDR_W-INDEX_W-OFFSET_W = 5
//  COUNT_W     16  hit/miss counter width
// PORTS
//  clk          in   1                  clock, all state updates on rising edge
//  rst          in   1                  asynchronous reset, active-high
//  cache_read   in   1                  CPU read request; held until cache_ready
//  cache_write  in   1                  reserved; ignored (no write path)
//  address      in   ADDR_W             CPU word address, stable while cache_read high
//  cache_ready  out  1                  one-cycle pulse: read_data valid, request done
//  read_data    out  DATA_W             requested word, valid when cache_ready=1
//  mem_read     out  1                  block fetch request to main memory
//  mem_address  out  ADDR_W-OFFSET_W    block address = address[ADDR_W-1:OFFSET_W]
//  mem_ready    in   1                  memory response strobe; mem_data valid
//  mem_data     in   DATA_W<<OFFSET_W   full block, word 0 in LSBs
//  hit_count    out  COUNT_W            completed hits, saturating
//  miss_count   out  COUNT_W            completed misses, saturating
// BEHAVIOUR
//  Reset (async): state=IDLE; cache_ready=0, read_data=0, mem_read=0, mem_address=0,
//   hit_count=0, miss_count=0, all valid bits=0; tag/data arrays not reset.
//  Address split: tag=addr[14:10], index=addr[9:2], offset=addr[1:0].
//  FSM:
//   IDLE: cache_read=1 -> latch address into req_addr, go LOOKUP; else stay.
//   LOOKUP: hit = valid[idx] && tag[idx]==req_tag.
//    hit -> read_data<=word[offset], hit_count++, go RESPOND.
//    miss -> mem_read<=1, mem_address<=req_addr[14:2], go FILL.
//   FILL: mem_read held high, mem_address stable until mem_ready=1.
//    On mem_ready: write block, tag, valid=1; read_data<=mem_data word[offset]; mem_read<=0;
//    miss_count++; go RESPOND. No fill timeout.
//   RESPOND: cache_ready=1 for exactly this cycle, go IDLE.
//  Latency from first clk edge sampling cache_read=1:
//   hit: cache_ready high in 3rd cycle (IDLE->LOOKUP->RESPOND).
//   miss: cache_ready high 1 cycle after the cycle mem_ready is sampled high.
//  Throughput: one request per 3 cycles on hits. CPU advances address on the cache_ready edge,
//   so IDLE sees the new address the next cycle; no request lost or duplicated.
//  mem_ready outside FILL is ignored. mem_data sampled only on the mem_ready edge in FILL.
//  cache_read dropped mid-request: request still completes and pulses cache_ready.
//  Counters saturate at 2^COUNT_W-1, no wrap.
//  Replacement: a miss overwrites the indexed line unconditionally. No write-back needed (read-only).
//  Reset mid-FILL: mem_read drops immediately, all lines invalid. A late mem_ready is ignored.
// STRUCTURE
//  Package cache_pkg: ADDR_W/INDEX_W/OFFSET_W/TAG_W/DATA_W constants;
//   state enum {IDLE,LOOKUP,FILL,RESPOND}; tag/index/offset extraction functions.
//  Sub-module cache_line_store: valid/tag/data arrays, combinational read by index,
//   synchronous block write, async clear of valid bits.
//  cache_controller: FSM, request latch, counters, memory handshake.
// TESTING
//  Cold miss: reset, read 1024 ->
//   mem_read=1, mem_address=256; mem_ready after 5 cycles with block {D3,D2,D1,D0};
//   cache_ready pulse with read_data=D0, miss_count=1.
//  Spatial hits: reads 1025,1026,1027 after above ->
//   each cache_ready in 3rd cycle, no mem_read, data D1..D3, hit_count=3.
//  Conflict: read 1024, then 2048 (same index 0, tag 1 vs 2), then 1024 ->
//   three misses, three fetches (mem_address 256,512,256).
//  Full CPU run: 8192 sequential reads from 1024 with 2-cycle memory ->
//   hit_count=6144, miss_count=2048, every address returns its memory word.
//  Reset mid-FILL: assert rst while mem_read=1 ->
//   mem_read=0 and cache_ready=0 immediately; re-read of the same address misses again.
//  Spurious mem_ready in IDLE/LOOKUP, and mem_ready delayed 20 cycles ->
//   no state change from the spurious strobe; mem_address stable for the whole wait.

Source files
------------

// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module : cache_pkg
// Brief  : Shared constants, FSM state type and address-field helpers for
//          the direct-mapped read-only cache controller.
//          Address layout (word address): tag | index | offset
//            tag    = addr[ADDR_W-1 : ADDR_W-TAG_W]
//            index  = addr[OFFSET_W+INDEX_W-1 : OFFSET_W]
//            offset = addr[OFFSET_W-1 : 0]
// Rev    : 1.0  initial release
// ============================================================================
package cache_pkg;

  localparam int ADDR_W          = 15;
  localparam int DATA_W          = 32;
  localparam int INDEX_W         = 8;
  localparam int OFFSET_W        = 2;
  localparam int TAG_W           = ADDR_W - INDEX_W - OFFSET_W;
  localparam int BADDR_W         = ADDR_W - OFFSET_W;
  localparam int WORDS_PER_BLOCK = 1 << OFFSET_W;
  localparam int BLOCK_W         = DATA_W << OFFSET_W;
  localparam int NUM_LINES       = 1 << INDEX_W;
  localparam int COUNT_W         = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    FILL    = 2'd2,
    RESPOND = 2'd3
  } state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W-1:0];
  endfunction

  function automatic logic [BADDR_W-1:0] addr_block(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:OFFSET_W];
  endfunction

  // Select one word out of a block; word 0 sits in the LSBs.
  function automatic logic [DATA_W-1:0] block_word(input logic [BLOCK_W-1:0]  blk,
                                                   input logic [OFFSET_W-1:0] off);
    return blk[int'(off) * DATA_W +: DATA_W];
  endfunction

endpackage : cache_pkg
`default_nettype wire

// File: rtl/cache_line_store.sv
`default_nettype none
// ============================================================================
// Module : cache_line_store
// Brief  : Line storage for the direct-mapped cache: valid bits, tags and
//          data blocks. Combinational read by index, synchronous single-line
//          write, asynchronous clear of the valid bits. Tag and data arrays
//          carry no reset; a line is only trusted once its valid bit is set.
// Ports  :
//   clk          in   clock
//   rst          in   async active-high reset, clears all valid bits
//   rd_index_i   in   line index to look up
//   rd_valid_o   out  valid bit of the indexed line
//   rd_tag_o     out  stored tag of the indexed line
//   rd_block_o   out  stored data block of the indexed line
//   wr_en_i      in   write strobe: install tag/block and mark valid
//   wr_index_i   in   line index to write
//   wr_tag_i     in   tag to install
//   wr_block_i   in   data block to install
// Rev    : 1.0  initial release
// ============================================================================
module cache_line_store
  import cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INDEX_W-1:0]   rd_index_i,
  output logic                 rd_valid_o,
  output logic [TAG_W-1:0]     rd_tag_o,
  output logic [BLOCK_W-1:0]   rd_block_o,
  input  logic                 wr_en_i,
  input  logic [INDEX_W-1:0]   wr_index_i,
  input  logic [TAG_W-1:0]     wr_tag_i,
  input  logic [BLOCK_W-1:0]   wr_block_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [BLOCK_W-1:0]   data_q [NUM_LINES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  // Storage arrays deliberately have no reset so they map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_block_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_block_o = data_q[rd_index_i];

endmodule : cache_line_store
`default_nettype wire

// File: rtl/cache_controller.sv
`default_nettype none
// ============================================================================
// Module : cache_controller
// Brief  : Direct-mapped read-only cache between the CPU request stage and
//          main memory. A read request is latched in IDLE, looked up in
//          LOOKUP, fetched as a whole block in FILL on a miss, and answered
//          with a one-cycle cache_ready pulse in RESPOND. Saturating hit and
//          miss counters support hit-rate measurement.
// Ports  :
//   clk          in   clock
//   rst          in   async active-high reset
//   cache_read   in   CPU read request, held until cache_ready
//   cache_write  in   reserved, ignored
//   address      in   CPU word address
//   cache_ready  out  one-cycle pulse, read_data valid
//   read_data    out  requested word
//   mem_read     out  block fetch request to memory
//   mem_address  out  block address of the fetch
//   mem_ready    in   memory response strobe
//   mem_data     in   full block from memory, word 0 in LSBs
//   hit_count    out  completed hits (saturating)
//   miss_count   out  completed misses (saturating)
// Rev    : 1.0  initial release
// ============================================================================
module cache_controller
  import cache_pkg::*;
#(
  parameter int COUNT_W_P = cache_pkg::COUNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cache_read,
  input  logic                 cache_write,
  input  logic [ADDR_W-1:0]    address,
  output logic                 cache_ready,
  output logic [DATA_W-1:0]    read_data,
  output logic                 mem_read,
  output logic [BADDR_W-1:0]   mem_address,
  input  logic                 mem_ready,
  input  logic [BLOCK_W-1:0]   mem_data,
  output logic [COUNT_W_P-1:0] hit_count,
  output logic [COUNT_W_P-1:0] miss_count
);

  // No write path exists; the port is kept for interface compatibility.
  logic unused_cache_write;
  assign unused_cache_write = cache_write;

  function automatic logic [COUNT_W_P-1:0] sat_inc(input logic [COUNT_W_P-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  state_t               state_q,       state_d;
  logic [ADDR_W-1:0]    req_addr_q,    req_addr_d;
  logic [DATA_W-1:0]    read_data_q,   read_data_d;
  logic                 mem_read_q,    mem_read_d;
  logic [BADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [COUNT_W_P-1:0] hit_count_q,   hit_count_d;
  logic [COUNT_W_P-1:0] miss_count_q,  miss_count_d;

  logic                 line_valid;
  logic [TAG_W-1:0]     line_tag;
  logic [BLOCK_W-1:0]   line_block;
  logic                 line_wr_en;
  logic                 lookup_hit;

  cache_line_store u_store (
    .clk        (clk),
    .rst        (rst),
    .rd_index_i (addr_index(req_addr_q)),
    .rd_valid_o (line_valid),
    .rd_tag_o   (line_tag),
    .rd_block_o (line_block),
    .wr_en_i    (line_wr_en),
    .wr_index_i (addr_index(req_addr_q)),
    .wr_tag_i   (addr_tag(req_addr_q)),
    .wr_block_i (mem_data)
  );

  assign lookup_hit = line_valid && (line_tag == addr_tag(req_addr_q));

  always_comb begin
    state_d       = state_q;
    req_addr_d    = req_addr_q;
    read_data_d   = read_data_q;
    mem_read_d    = mem_read_q;
    mem_address_d = mem_address_q;
    hit_count_d   = hit_count_q;
    miss_count_d  = miss_count_q;
    line_wr_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (cache_read) begin
          req_addr_d = address;
          state_d    = LOOKUP;
        end
      end

      LOOKUP: begin
        if (lookup_hit) begin
          read_data_d = block_word(line_block, addr_offset(req_addr_q));
          hit_count_d = sat_inc(hit_count_q);
          state_d     = RESPOND;
        end else begin
          mem_read_d    = 1'b1;
          mem_address_d = addr_block(req_addr_q);
          state_d       = FILL;
        end
      end

      // mem_data is only trusted on the strobe; the returned word is taken
      // straight from the bus so RESPOND does not need another array read.
      FILL: begin
        if (mem_ready) begin
          line_wr_en   = 1'b1;
          read_data_d  = block_word(mem_data, addr_offset(req_addr_q));
          mem_read_d   = 1'b0;
          miss_count_d = sat_inc(miss_count_q);
          state_d      = RESPOND;
        end
      end

      RESPOND: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      req_addr_q    <= '0;
      read_data_q   <= '0;
      mem_read_q    <= 1'b0;
      mem_address_q <= '0;
      hit_count_q   <= '0;
      miss_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      req_addr_q    <= req_addr_d;
      read_data_q   <= read_data_d;
      mem_read_q    <= mem_read_d;
      mem_address_q <= mem_address_d;
      hit_count_q   <= hit_count_d;
      miss_count_q  <= miss_count_d;
    end
  end

  // Decoded from state so the pulse drops together with an async reset.
  assign cache_ready = (state_q == RESPOND);
  assign read_data   = read_data_q;
  assign mem_read    = mem_read_q;
  assign mem_address = mem_address_q;
  assign hit_count   = hit_count_q;
  assign miss_count  = miss_count_q;

endmodule : cache_controller
`default_nettype wire

// File: tb/tb_cache_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_cache_controller
// Brief  : Directed self-checking bench for cache_controller. A behavioural
//          main memory returns a distinct word per address; each read is
//          checked for data, hit/miss, latency and single-cycle cache_ready.
// Rev    : 1.0  initial release
// ============================================================================
module tb_cache_controller;
  import cache_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cache_read;
  logic                 cache_write;
  logic [ADDR_W-1:0]    address;
  logic                 cache_ready;
  logic [DATA_W-1:0]    read_data;
  logic                 mem_read;
  logic [BADDR_W-1:0]   mem_address;
  logic                 mem_ready;
  logic [BLOCK_W-1:0]   mem_data;
  logic [COUNT_W-1:0]   hit_count;
  logic [COUNT_W-1:0]   miss_count;

  localparam logic [BLOCK_W-1:0] JUNK = 128'hDEAD_BEEF_0BAD_F00D_DEAD_BEEF_0BAD_F00D;

  int n_cmp = 0;
  int n_err = 0;

  cache_controller dut (
    .clk         (clk),
    .rst         (rst),
    .cache_read  (cache_read),
    .cache_write (cache_write),
    .address     (address),
    .cache_ready (cache_ready),
    .read_data   (read_data),
    .mem_read    (mem_read),
    .mem_address (mem_address),
    .mem_ready   (mem_ready),
    .mem_data    (mem_data),
    .hit_count   (hit_count),
    .miss_count  (miss_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish before 2ms");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Main-memory contents: a unique, nonzero word for every address.
  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {~a, 2'b10, a};
  endfunction

  function automatic logic [BLOCK_W-1:0] mem_block(input logic [BADDR_W-1:0] b);
    logic [BLOCK_W-1:0] r;
    for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
      r[i*DATA_W +: DATA_W] = mem_word({b, 2'(i)});
    end
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    cache_read = 1'b0;
    mem_ready  = 1'b0;
    mem_data   = JUNK;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One CPU read. Called and returns at posedge+1 with the DUT in IDLE.
  // Hit: cache_ready seen 2 edges after the call; miss: 3 + delay edges.
  // spur: mem_ready pulsed while the DUT is in IDLE and LOOKUP (junk data).
  // drop: cache_read released right after the request is accepted.
  task automatic do_read(input logic [ADDR_W-1:0] a, input int delay, input bit exp_hit,
                         input bit spur, input bit drop, output logic [BADDR_W-1:0] faddr);
    int                 cyc      = 0;
    int                 wait_cnt = 0;
    bit                 done     = 1'b0;
    bit                 fetched  = 1'b0;
    logic [BADDR_W-1:0] first_addr = '0;
    address     = a;
    cache_read  = 1'b1;
    cache_write = 1'b0;
    mem_ready   = spur;
    mem_data    = JUNK;
    while (!done && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      mem_ready = spur && (cyc == 1);
      mem_data  = JUNK;
      if (drop && cyc == 1) cache_read = 1'b0;
      if (cache_ready) begin
        done = 1'b1;
      end else if (mem_read) begin
        if (!fetched) first_addr = mem_address;
        fetched = 1'b1;
        if (spur) check("mem_addr_stable", mem_address, first_addr);
        if (wait_cnt == delay) begin
          mem_ready = 1'b1;
          mem_data  = mem_block(mem_address);
        end
        wait_cnt++;
      end
    end
    faddr = first_addr;
    check("resp_seen", done, 1'b1);
    check("rdata", read_data, mem_word(a));
    check("hit", !fetched, exp_hit);
    check("latency", cyc, exp_hit ? 2 : 3 + delay);
    cache_read = 1'b0;
    mem_ready  = 1'b0;
    mem_data   = JUNK;
    @(posedge clk);
    #1;
    check("ready_pulse_1cyc", cache_ready, 1'b0);
  endtask

  logic [BADDR_W-1:0] fa;

  initial begin
    rst         = 1'b1;
    cache_read  = 1'b0;
    cache_write = 1'b0;
    address     = '0;
    mem_ready   = 1'b0;
    mem_data    = JUNK;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", cache_ready, 1'b0);
    check("rst_rdata", read_data, 32'd0);
    check("rst_memread", mem_read, 1'b0);
    check("rst_memaddr", mem_address, 13'd0);
    check("rst_hits", hit_count, 16'd0);
    check("rst_misses", miss_count, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Cold miss with 5-cycle memory, then spatial hits in the same block.
    do_read(15'd1024, 5, 1'b0, 1'b0, 1'b0, fa);
    check("cold_faddr", fa, 13'd256);
    check("cold_misses", miss_count, 16'd1);
    check("cold_hits", hit_count, 16'd0);
    for (int i = 1; i < 4; i++) begin
      do_read(15'(1024 + i), 2, 1'b1, 1'b0, 1'b0, fa);
    end
    check("spatial_hits", hit_count, 16'd3);
    check("spatial_misses", miss_count, 16'd1);

    // Spurious memory strobe while idle.
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mem_ready = 1'b0;
    check("spur_idle_memread", mem_read, 1'b0);
    check("spur_idle_ready", cache_ready, 1'b0);
    check("spur_idle_misses", miss_count, 16'd1);
    check("spur_idle_hits", hit_count, 16'd3);

    // Conflict on index 0: tag 1, tag 2, tag 1 again.
    do_reset();
    do_read(15'd1024, 1, 1'b0, 1'b0, 1'b0, fa);
    check("conf_faddr0", fa, 13'd256);
    do_read(15'd2048, 1, 1'b0, 1'b0, 1'b0, fa);
    check("conf_faddr1", fa, 13'd512);
    do_read(15'd1024, 1, 1'b0, 1'b0, 1'b0, fa);
    check("conf_faddr2", fa, 13'd256);
    check("conf_misses", miss_count, 16'd3);
    check("conf_hits", hit_count, 16'd0);

    // cache_read dropped after acceptance: both a hit and a miss complete.
    do_read(15'd1025, 0, 1'b1, 1'b0, 1'b1, fa);
    do_read(15'd3000, 1, 1'b0, 1'b0, 1'b1, fa);
    check("drop_hits", hit_count, 16'd1);
    check("drop_misses", miss_count, 16'd4);

    // Spurious strobe in IDLE and LOOKUP, then a 20-cycle memory wait.
    do_read(15'd4000, 20, 1'b0, 1'b1, 1'b0, fa);
    check("slow_faddr", fa, 13'd1000);
    check("slow_misses", miss_count, 16'd5);

    // Reset during FILL.
    address    = 15'd5000;
    cache_read = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rstfill_pre_memread", mem_read, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("rstfill_memread", mem_read, 1'b0);
    check("rstfill_ready", cache_ready, 1'b0);
    check("rstfill_misses", miss_count, 16'd0);
    cache_read = 1'b0;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    mem_ready = 1'b1;
    mem_data  = mem_block(13'd1250);
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    mem_data  = JUNK;
    check("late_memready_memread", mem_read, 1'b0);
    check("late_memready_ready", cache_ready, 1'b0);
    check("late_memready_misses", miss_count, 16'd0);
    do_read(15'd5000, 2, 1'b0, 1'b0, 1'b0, fa);
    do_read(15'd1025, 2, 1'b0, 1'b0, 1'b0, fa);
    check("post_rst_misses", miss_count, 16'd2);

    // Full sequential CPU run with 2-cycle memory.
    do_reset();
    for (int a = 1024; a < 1024 + 8192; a++) begin
      do_read(15'(a), 2, (a % 4) != 0, 1'b0, 1'b0, fa);
    end
    check("run_hits", hit_count, 16'd6144);
    check("run_misses", miss_count, 16'd2048);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_cache_controller
`default_nettype wire
